sync_fifo: RTL

- Single-clock synchronous FIFO. It is the DUT that the FIFO testbench driver stimulates and the monitor observes.
- Accepts write/read enables and data, stores entries in a register-file memory, and returns registered read data.
- Exports full, empty, almost_full, almost_empty and half status flags, plus an occupancy count and overflow/underflow error pulses.

---
 rtl/sync_fifo.sv | 100 ++++++++++
 1 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a register-file store and registered read data.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   wr_enb       write request; wr_data is stored when accepted (not full)
//   wr_data      write data
//   rd_enb       read request; rd_data updates the following cycle when accepted
//   rd_data      registered read data, holds when no read is accepted
//   full/empty   count == DEPTH / count == 0
//   almost_full  count >= AFULL_LVL
//   almost_empty count <= AEMPTY_LVL
//   half         count >= DEPTH/2
//   count        current occupancy (0..DEPTH)
//   overflow     one-cycle pulse after a write requested while full
//   underflow    one-cycle pulse after a read requested while empty
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = 14,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_enb,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_enb,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    half,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if ((1 << AW) != DEPTH || DEPTH < 4) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of 2 and at least 4");
  end
  if (!(AEMPTY_LVL > 0 && AEMPTY_LVL < AFULL_LVL && AFULL_LVL < DEPTH)) begin : g_bad_lvl
    $error("sync_fifo: require 0 < AEMPTY_LVL < AFULL_LVL < DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags come from the count register only, so they clear with the
  // asynchronous reset without waiting for an edge.
  always_comb begin
    full         = (count == CW'(DEPTH));
    empty        = (count == '0);
    almost_full  = (count >= CW'(AFULL_LVL));
    almost_empty = (count <= CW'(AEMPTY_LVL));
    half         = (count >= CW'(DEPTH / 2));
    wr_acc       = wr_enb & ~full;
    rd_acc       = rd_enb & ~empty;
  end

  // Storage is not reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (wr_acc && rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_enb & full;
      underflow <= rd_enb & empty;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
